// File: rtl/led_pattern_engine.sv
// LED pattern generator: count up/down, rotate, bounce, stepped by an internal clock-enable tick.
// Define LED_PWM_EN to add PWM brightness dimming on the led outputs (duty PWM_DUTY/8).
module led_pattern_engine #(
   parameter int unsigned LED_W    = 4,
   parameter int unsigned TICK_DIV = 25_000_000,
   parameter int unsigned PWM_DUTY = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       sw,
   output logic [LED_W-1:0] led,
   output logic             step
);

   localparam int unsigned     CW       = $clog2(TICK_DIV);
   localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);

   localparam logic [1:0] M_UP  = 2'b00;
   localparam logic [1:0] M_DN  = 2'b01;
   localparam logic [1:0] M_ROT = 2'b10;
   localparam logic [1:0] M_BNC = 2'b11;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   if (LED_W < 2 || TICK_DIV < 2 || PWM_DUTY > 8) begin : g_bad_param
      $error("led_pattern_engine: parameter out of range");
   end

   logic [1:0]       sync1_q, sync2_q;
   logic [1:0]       mode_q, mode_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [LED_W-1:0] pat_q, pat_d;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic             tick, mode_chg;

   function automatic logic [LED_W-1:0] init_pat(input logic [1:0] m);
      case (m)
         M_UP:    init_pat = '0;
         M_DN:    init_pat = '1;
         default: init_pat = LED_W'(1);
      endcase
   endfunction

   // A pending mode change takes priority over a coincident tick.
   always_comb begin
      tick     = (cnt_q == CNT_LAST);
      mode_chg = (sync2_q != mode_q);
      mode_d   = mode_q;
      pat_d    = pat_q;
      dir_d    = dir_q;
      cnt_d    = tick ? '0 : cnt_q + CW'(1);
      step_d   = tick && !mode_chg;
      if (mode_chg) begin
         mode_d = sync2_q;
         pat_d  = init_pat(sync2_q);
         dir_d  = DIR_LEFT;
         cnt_d  = '0;
      end else if (tick) begin
         case (mode_q)
            M_UP:  pat_d = pat_q + LED_W'(1);
            M_DN:  pat_d = pat_q - LED_W'(1);
            M_ROT: pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
            default: begin
               if (dir_q == DIR_LEFT) begin
                  if (pat_q[LED_W-1]) begin
                     pat_d = pat_q >> 1;
                     dir_d = DIR_RIGHT;
                  end else begin
                     pat_d = pat_q << 1;
                  end
               end else begin
                  if (pat_q[0]) begin
                     pat_d = pat_q << 1;
                     dir_d = DIR_LEFT;
                  end else begin
                     pat_d = pat_q >> 1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         mode_q  <= M_UP;
         cnt_q   <= '0;
         pat_q   <= '0;
         dir_q   <= DIR_LEFT;
         step_q  <= 1'b0;
      end else begin
         sync1_q <= sw;
         sync2_q <= sync1_q;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         pat_q   <= pat_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
      end
   end

   assign step = step_q;

`ifdef LED_PWM_EN
   logic [2:0]       pwm_q;
   logic [LED_W-1:0] led_q;
   logic             pwm_on;

   assign pwm_on = ({1'b0, pwm_q} < 4'(PWM_DUTY));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwm_q <= '0;
         led_q <= '0;
      end else begin
         pwm_q <= pwm_q + 3'd1;
         led_q <= pat_q & {LED_W{pwm_on}};
      end
   end

   assign led = led_q;
`else
   assign led = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine: 4-LED/div-4 instance plus a 2-LED/div-2 boundary instance.
module tb_led_pattern_engine;

   logic       clk;
   logic       rst;
   logic [1:0] sw_a, sw_b;
   logic [3:0] led_a;
   logic [1:0] led_b;
   logic       step_a, step_b;

   int checks   = 0;
   int failures = 0;
   logic [3:0] exp_q[$];

   led_pattern_engine #(.LED_W(4), .TICK_DIV(4)) dut_a (
      .clk(clk), .rst(rst), .sw(sw_a), .led(led_a), .step(step_a)
   );

   led_pattern_engine #(.LED_W(2), .TICK_DIV(2)) dut_b (
      .clk(clk), .rst(rst), .sw(sw_b), .led(led_b), .step(step_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for the next step pulse, sampled on the falling edge.
   task automatic wait_step(input bit sel, input int limit, output int n,
                            output logic s, output logic [3:0] l);
      n = 0;
      s = 1'b0;
      while (!s && n < limit) begin
         @(negedge clk);
         n++;
         s = sel ? step_b : step_a;
      end
      l = sel ? {2'b00, led_b} : led_a;
   endtask

   task automatic pop_check(input bit sel, input int interval, input string tag);
      int         n;
      logic       s;
      logic [3:0] l;
      logic [3:0] e;
      wait_step(sel, interval * 3, n, s, l);
      e = exp_q.pop_front();
      check({tag, "_step_seen"}, {31'd0, s}, 32'd1);
      check({tag, "_led"}, {28'd0, l}, {28'd0, e});
      check({tag, "_interval"}, n, interval);
   endtask

   initial begin
      rst  = 1'b0;
      sw_a = 2'b00;
      sw_b = 2'b11;
      repeat (2) @(negedge clk);
      check("reset_led_a", {28'd0, led_a}, 32'd0);
      check("reset_step_a", {31'd0, step_a}, 32'd0);
      check("reset_led_b", {30'd0, led_b}, 32'd0);

      // COUNT_UP: first advance on the 4th edge after release
      rst = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("up_pre_step", {31'd0, step_a}, 32'd0);
         check("up_pre_led", {28'd0, led_a}, 32'd0);
      end
      @(negedge clk);
      check("up_first_step", {31'd0, step_a}, 32'd1);
      check("up_first_led", {28'd0, led_a}, 32'd1);
      for (int v = 2; v <= 16; v++) exp_q.push_back(4'(v));
      for (int i = 0; i < 15; i++) pop_check(1'b0, 4, "up");

      // COUNT_DN reload three edges after sw is sampled
      sw_a = 2'b01;
      repeat (3) @(negedge clk);
      check("dn_reload_led", {28'd0, led_a}, 32'hF);
      check("dn_reload_step", {31'd0, step_a}, 32'd0);
      exp_q.push_back(4'hE);
      exp_q.push_back(4'hD);
      exp_q.push_back(4'hC);
      for (int i = 0; i < 3; i++) pop_check(1'b0, 4, "dn");

      // Reload edge coincides with cnt==3
      @(negedge clk);
      sw_a = 2'b10;
      repeat (3) @(negedge clk);
      check("coll_led", {28'd0, led_a}, 32'h1);
      check("coll_step", {31'd0, step_a}, 32'd0);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      for (int i = 0; i < 2; i++) pop_check(1'b0, 4, "rot");

      // Asynchronous reset mid-ROTATE, between clock edges
      #2 rst = 1'b0;
      #1;
      check("async_rst_led_a", {28'd0, led_a}, 32'd0);
      check("async_rst_step_a", {31'd0, step_a}, 32'd0);
      check("async_rst_led_b", {30'd0, led_b}, 32'd0);

      // BOUNCE
      @(negedge clk);
      rst  = 1'b1;
      sw_a = 2'b11;
      repeat (3) @(negedge clk);
      check("bnc_reload_led", {28'd0, led_a}, 32'h1);
      check("bnc_reload_step", {31'd0, step_a}, 32'd0);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000);
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      for (int i = 0; i < 7; i++) pop_check(1'b0, 4, "bnc");

      // Boundary width: 2 LEDs, divide by 2, BOUNCE held on sw from time zero
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("w2_reload_led", {30'd0, led_b}, 32'h1);
      check("w2_reload_step", {31'd0, step_b}, 32'd0);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0001);
      for (int i = 0; i < 4; i++) pop_check(1'b1, 2, "w2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
